retospect_cfg_loader: RTL and testbench
=======================================

Name: retospect_cfg_loader

Overview:
- Bitstream programmer that drives the neurochip configuration shift chain (the chain's config_en / bs_in / bs_out path).
- Accepts configuration bytes over a valid/ready stream and serialises exactly CHAIN_LEN bits into the chain, LSB first.
- Captures the old chain contents emerging on the chain's bs_out into a readback byte stream.
- On completion, optionally issues a one-cycle reset_nn pulse and signals done.

Parameters:
- CHAIN_LEN, 523, total chain bits (6x8 clockbox + 25x19 cell bits).
- PULSE_NN, 1, 1 = emit one-cycle chain_reset_nn after the load completes.
- CNT_W, 10, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load; ignored unless in IDLE.
- rb_en  in  1  sampled at start; 1 = readback enabled, 0 = readback bits discarded.
- s_valid  in  1  config byte valid.
- s_data  in  8  config byte, bit 0 shifted first.
- s_ready  out  1  loader accepts byte.
- cfg_en  out  1  to chain config_en, registered.
- cfg_bs  out  1  to chain bs_in, registered.
- chain_bs  in  1  from chain bs_out (combinational from chain flop).
- chain_reset_nn  out  1  to chain reset_nn, registered.
- m_valid  out  1  readback byte valid.
- m_data  out  8  readback byte, first-emerged bit in bit 0.
- m_ready  in  1  readback consumer ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a load.

Behaviour:
- Reset values:
  - Outputs: cfg_en=0, cfg_bs=0, chain_reset_nn=0, s_ready=0, m_valid=0, m_data=0, busy=0, done=0.
  - Internal: state=IDLE, all counters 0, byte registers empty.
- States: IDLE -> LOAD -> FLUSH -> NN -> DONE -> IDLE.
- IDLE: start=1 clears counters, latches rb_en, goes to LOAD. s_ready=0 in IDLE.
- LOAD, input side:
  - 8-bit input shift register plus a bit-count; s_ready=1 when the register is empty or its last bit issues this cycle.
  - Handshake on s_valid&s_ready.
- LOAD, shift issue:
  - A shift is issued at an edge by registering cfg_en=1 with cfg_bs = next input bit.
  - Issue requires an input bit available AND no readback overflow risk.
  - Overflow rule: issue only if rb_en=0 OR (asm_cnt + cfg_en) < 8 OR holding register free/draining (!m_valid | m_ready).
  - Otherwise cfg_en=0 and the chain holds its contents.
  - Input underflow (no byte): cfg_en=0; not an error.
- LOAD, readback capture:
  - At each edge where cfg_en=1, chain_bs is sampled into the assembly register at position asm_cnt; the chain shifts on that same edge.
  - When asm_cnt reaches 8, the byte moves to the holding register (m_valid=1) if free; otherwise it waits in assembly (the issue rule guarantees no loss).
- LOAD exit:
  - bit_cnt counts issued shifts; after the CHAIN_LEN-th issue, cfg_en=0 on the next cycle and state -> FLUSH.
  - Remaining bits of a partially consumed last byte (CHAIN_LEN mod 8) are discarded. No further bytes are accepted.
- FLUSH:
  - If rb_en and asm_cnt>0, the partial byte is zero-padded in the high bits and presented on m_valid.
  - Stay until the holding register and assembly register are empty, then -> NN.
- NN: if PULSE_NN, chain_reset_nn=1 for exactly one cycle; -> DONE. If PULSE_NN=0, pass straight through NN without asserting chain_reset_nn.
- DONE: done=1 for one cycle; -> IDLE.
- Chain ordering: the first bit issued ends deepest in the chain (at the chain bs_out end).
- Reset mid-load: all outputs return to reset values on the next edge; the chain is left partially loaded; no done pulse.
- Simultaneous events:
  - start while busy: ignored.
  - m_ready and a new byte completing in the same cycle: the holding register reloads with no bubble.
- Throughput: 1 bit/clk when the input stream is continuous and readback is not back-pressured.
- Bytes required per load = ceil(CHAIN_LEN/8).

Decomposition:
- Shared package retospect_cfg_pkg:
  - state enum (IDLE, LOAD, FLUSH, NN, DONE);
  - constants CLOCKBOX_BITS=48, CNB_BITS=19, default grid 5x5, derived CHAIN_LEN.
- One natural sub-module: retospect_rb_packer. It holds the readback assembly register, holding register, valid/ready logic and the flush/pad behaviour, and exports a can_accept signal for the issue rule.

Test Plan:
- CHAIN_LEN=12, chain model preloaded 0xABC; bytes 0x5A, 0x03 streamed with m_ready=1:
  - exactly 12 cfg_en cycles;
  - chain ends 0x35A (first bit deepest);
  - readback 0xBC then 0x0A;
  - one chain_reset_nn pulse, then done.
- Same load with s_valid gapped 3 cycles between bytes: cfg_en drops during gaps; final chain contents and readback identical; bit count still 12.
- rb_en=1, m_ready held 0 for 20 cycles mid-load:
  - cfg_en stalls once 8 assembled bits plus 8 held are pending;
  - no readback bit lost;
  - released stream yields correct bytes.
- Default CHAIN_LEN=523, all-ones pattern over an all-zero chain:
  - 66 bytes accepted, last byte only 3 bits used;
  - 66 readback bytes, last = 0x00 padded;
  - chain all ones.
- reset asserted at bit 5 of a load: next cycle cfg_en=0, busy=0, s_ready=0, no done. A subsequent start performs a full correct load.
- start pulsed during LOAD, and rb_en=0 load: the second start has no effect. With rb_en=0, m_valid never asserts and m_ready=0 never stalls cfg_en.

Source files
------------

// File: rtl/retospect_cfg_pkg.sv
// Shared types and geometry constants for the neurochip configuration loader.
// The default chain length is derived from the clockbox and the cell grid.
package retospect_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        NN,
        DONE
    } state_t;

    localparam int BYTE_W        = 8;
    localparam int CLOCKBOX_BITS = 48;
    localparam int CNB_BITS      = 19;
    localparam int GRID_W        = 5;
    localparam int GRID_H        = 5;

    localparam int DEFAULT_CHAIN_LEN = CLOCKBOX_BITS + GRID_W * GRID_H * CNB_BITS;

endpackage

// File: rtl/retospect_rb_packer.sv
// Readback packer: assembles bits leaving the chain into bytes, double-buffers
// them against a valid/ready consumer and pads the final partial byte.
module retospect_rb_packer
    import retospect_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              rb_en,
    input  logic              cfg_en,
    input  logic              chain_bs,
    input  logic              flush,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [BYTE_W-1:0] m_data,
    output logic              can_accept,
    output logic              empty
);

    logic [BYTE_W-1:0] asm_q;
    logic [3:0]        asm_cnt;
    logic              capture;
    logic              hold_free;
    logic              full_move;
    logic              pad_move;
    logic              move;

    assign capture   = rb_en && cfg_en;
    assign hold_free = !m_valid || m_ready;
    assign full_move = (asm_cnt == 4'd8) && hold_free;
    assign pad_move  = flush && (asm_cnt != 4'd0) && hold_free;
    assign move      = full_move || pad_move;

    // A new shift is only safe if the bit it will return has somewhere to land:
    // count the capture happening at this edge as already pending.
    assign can_accept = !rb_en
                     || ((asm_cnt + {3'b000, cfg_en}) < 4'd8)
                     || hold_free;

    assign empty = (asm_cnt == 4'd0) && !m_valid;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            asm_q   <= '0;
            asm_cnt <= 4'd0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (move) begin
                m_data  <= asm_q;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            // Assembly is cleared on every move so unused high bits read as zero.
            if (move) begin
                asm_q   <= capture ? {{(BYTE_W-1){1'b0}}, chain_bs} : '0;
                asm_cnt <= capture ? 4'd1 : 4'd0;
            end else if (capture) begin
                asm_q[asm_cnt[2:0]] <= chain_bs;
                asm_cnt             <= asm_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/retospect_cfg_loader.sv
// Configuration chain programmer: serialises a byte stream LSB first into the
// neurochip shift chain and returns the displaced contents as a byte stream.
module retospect_cfg_loader
    import retospect_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter bit PULSE_NN  = 1'b1,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rb_en,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       cfg_en,
    output logic       cfg_bs,
    input  logic       chain_bs,
    output logic       chain_reset_nn,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       in_sr;
    logic [3:0]       in_cnt;
    logic             rb_en_q;
    logic             can_accept;
    logic             rb_empty;
    logic             issue;
    logic             last_issue;
    logic             accept;
    logic             clear;
    logic             flush;

    assign issue      = (state == LOAD) && (in_cnt != 4'd0) && can_accept;
    assign last_issue = issue && (bit_cnt == LAST_BIT);

    // Ready early when the last buffered bit leaves this cycle, so a
    // continuous stream sustains one bit per clock.
    assign s_ready = (state == LOAD)
                  && ((in_cnt == 4'd0) || ((in_cnt == 4'd1) && issue && !last_issue));

    assign accept = s_valid && s_ready;
    assign clear  = (state == IDLE) && start;
    assign flush  = (state == FLUSH) && !cfg_en;
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (last_issue) state_next = FLUSH;
            FLUSH:   if (!cfg_en && rb_empty) state_next = NN;
            NN:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_en         <= 1'b0;
            cfg_bs         <= 1'b0;
            chain_reset_nn <= 1'b0;
            done           <= 1'b0;
            bit_cnt        <= '0;
            in_sr          <= '0;
            in_cnt         <= 4'd0;
            rb_en_q        <= 1'b0;
        end else begin
            cfg_en         <= issue;
            cfg_bs         <= issue & in_sr[0];
            chain_reset_nn <= PULSE_NN && (state_next == NN);
            done           <= (state_next == DONE);

            if (clear) begin
                bit_cnt <= '0;
                in_sr   <= '0;
                in_cnt  <= 4'd0;
                rb_en_q <= rb_en;
            end else begin
                if (issue) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                // Leftover bits of the final byte beyond the chain are dropped.
                if (last_issue) begin
                    in_sr  <= '0;
                    in_cnt <= 4'd0;
                end else if (accept) begin
                    in_sr  <= s_data;
                    in_cnt <= 4'd8;
                end else if (issue) begin
                    in_sr  <= {1'b0, in_sr[7:1]};
                    in_cnt <= in_cnt - 4'd1;
                end
            end
        end
    end

    retospect_rb_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .rb_en      (rb_en_q),
        .cfg_en     (cfg_en),
        .chain_bs   (chain_bs),
        .flush      (flush),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .can_accept (can_accept),
        .empty      (rb_empty)
    );

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Bench for the configuration loader: a 12-bit and a full-length instance,
// each driving a behavioural shift-chain model, with a readback scoreboard.
module tb_retospect_cfg_loader;

    localparam int LS  = 12;
    localparam int LL  = 523;
    localparam int NBL = 66;

    logic clk = 1'b0;
    logic reset, start, rb_en, s_valid, m_ready, sel;
    logic [7:0] s_data;
    logic start_s, start_l;

    logic s_ready_s, cfg_en_s, cfg_bs_s, chain_bs_s, nn_s, m_valid_s, busy_s, done_s;
    logic s_ready_l, cfg_en_l, cfg_bs_l, chain_bs_l, nn_l, m_valid_l, busy_l, done_l;
    logic [7:0] m_data_s, m_data_l;

    logic s_ready_m, cfg_en_m, nn_m, m_valid_m, busy_m, done_m;
    logic [7:0] m_data_m;

    logic [LS-1:0] ch_s, pre_s;
    logic [LL-1:0] ch_l, pre_l;
    logic pre_ld_s, pre_ld_l;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_cnt, en_first, en_last, nn_cnt, nn_t, done_cnt, done_t;
    int mv_cnt, acc_cnt, rb_cnt;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign start_s = start & ~sel;
    assign start_l = start & sel;

    retospect_cfg_loader #(.CHAIN_LEN(LS), .PULSE_NN(1'b1), .CNT_W(10)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .rb_en(rb_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_s),
        .cfg_en(cfg_en_s), .cfg_bs(cfg_bs_s), .chain_bs(chain_bs_s),
        .chain_reset_nn(nn_s), .m_valid(m_valid_s), .m_data(m_data_s),
        .m_ready(m_ready), .busy(busy_s), .done(done_s)
    );

    retospect_cfg_loader #(.CHAIN_LEN(LL), .PULSE_NN(1'b1), .CNT_W(10)) dut_l (
        .clk(clk), .reset(reset), .start(start_l), .rb_en(rb_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_l),
        .cfg_en(cfg_en_l), .cfg_bs(cfg_bs_l), .chain_bs(chain_bs_l),
        .chain_reset_nn(nn_l), .m_valid(m_valid_l), .m_data(m_data_l),
        .m_ready(m_ready), .busy(busy_l), .done(done_l)
    );

    // Chain model: shifts toward bit 0, which drives bs_out.
    always @(posedge clk) begin
        if (pre_ld_s) ch_s <= pre_s;
        else if (cfg_en_s) ch_s <= {cfg_bs_s, ch_s[LS-1:1]};
        if (pre_ld_l) ch_l <= pre_l;
        else if (cfg_en_l) ch_l <= {cfg_bs_l, ch_l[LL-1:1]};
    end
    assign chain_bs_s = ch_s[0];
    assign chain_bs_l = ch_l[0];

    assign s_ready_m = sel ? s_ready_l : s_ready_s;
    assign cfg_en_m  = sel ? cfg_en_l  : cfg_en_s;
    assign nn_m      = sel ? nn_l      : nn_s;
    assign m_valid_m = sel ? m_valid_l : m_valid_s;
    assign m_data_m  = sel ? m_data_l  : m_data_s;
    assign busy_m    = sel ? busy_l    : busy_s;
    assign done_m    = sel ? done_l    : done_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out waiting for the DUT", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (cfg_en_m) begin
                if (en_cnt == 0) en_first = cyc;
                en_last = cyc;
                en_cnt++;
            end
            if (nn_m) begin nn_cnt++; nn_t = cyc; end
            if (done_m) begin done_cnt++; done_t = cyc; end
            if (s_valid && s_ready_m) acc_cnt++;
            if (m_valid_m) mv_cnt++;
            if (m_valid_m && m_ready) begin
                rb_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rb_extra actual=%0h expected=none", m_data_m);
                end else begin
                    e = exp_q.pop_front();
                    check("rb_byte", 32'(m_data_m), 32'(e));
                end
            end
        end
    endtask

    task automatic clr();
        en_cnt = 0; en_first = 0; en_last = 0; nn_cnt = 0; nn_t = 0;
        done_cnt = 0; done_t = 0; mv_cnt = 0; acc_cnt = 0; rb_cnt = 0;
        exp_q.delete();
    endtask

    task automatic do_start(input logic rbv);
        rb_en = rbv;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        rb_en = ~rbv;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            t = 0;
            @(negedge clk);
            while (!s_ready_m && t < 200) begin @(negedge clk); t++; end
            if (!s_ready_m) timeout("gap_ready");
            tick(gap);
        end
        s_data = b;
        s_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_ready_m && t < 5000) begin @(negedge clk); t++; end
        if (!s_ready_m) timeout("s_ready");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!done_m && t < 3000) begin @(negedge clk); t++; end
        if (!done_m) timeout(name);
        tick(2);
    endtask

    task automatic run_small(input int gap, input logic rb, input string pfx);
        pre_s = 12'hABC; pre_ld_s = 1'b1; tick(1); pre_ld_s = 1'b0;
        clr();
        if (rb) begin exp_q.push_back(8'hBC); exp_q.push_back(8'h0A); end
        sel = 1'b0;
        m_ready = 1'b1;
        do_start(rb);
        send_byte(8'h5A, 0);
        send_byte(8'h03, gap);
        wait_done({pfx, "_done"});
        check({pfx, "_en_cnt"}, 32'(en_cnt), 32'd12);
        check({pfx, "_chain"}, 32'(ch_s), 32'h35A);
        check({pfx, "_nn_cnt"}, 32'(nn_cnt), 32'd1);
        check({pfx, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({pfx, "_nn_to_done"}, 32'(done_t - nn_t), 32'd1);
        check({pfx, "_acc"}, 32'(acc_cnt), 32'd2);
        check({pfx, "_rb_cnt"}, 32'(rb_cnt), rb ? 32'd2 : 32'd0);
        check({pfx, "_rb_left"}, 32'(exp_q.size()), 32'd0);
        if (gap == 0) check({pfx, "_span"}, 32'(en_last - en_first + 1), 32'd12);
        else check({pfx, "_gapped"}, 32'(en_last - en_first + 1 > 12), 32'd1);
    endtask

    task automatic stall_watch();
        int t;
        int bad;
        t = 0;
        bad = 0;
        while (en_cnt < 16 && t < 300) begin @(posedge clk); t++; end
        if (en_cnt < 16) timeout("stall_reach");
        check("stall_bits", 32'(en_cnt), 32'd16);
        repeat (20) begin
            @(negedge clk);
            if (cfg_en_m) bad++;
        end
        check("stall_en_low", 32'(bad), 32'd0);
        check("stall_hold", 32'(en_cnt), 32'd16);
        check("stall_mvalid", 32'(m_valid_m), 32'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
    endtask

    task automatic run_large(input logic ones, input string pfx);
        logic [527:0] pv;
        logic [527:0] bv;
        for (int k = 0; k < NBL; k++) begin
            pv[8*k +: 8] = ones ? 8'h00 : 8'(k * 53 + 19);
            bv[8*k +: 8] = ones ? 8'hFF : 8'(k * 29 + 7);
        end
        pv[527:LL] = '0;
        pre_l = pv[LL-1:0]; pre_ld_l = 1'b1; tick(1); pre_ld_l = 1'b0;
        clr();
        for (int k = 0; k < NBL; k++) exp_q.push_back(pv[8*k +: 8]);
        sel = 1'b1;
        m_ready = ones;
        do_start(1'b1);
        fork
            begin
                for (int k = 0; k < NBL; k++) send_byte(bv[8*k +: 8], 0);
            end
            begin
                if (!ones) stall_watch();
            end
        join
        wait_done({pfx, "_done"});
        check({pfx, "_en_cnt"}, 32'(en_cnt), 32'(LL));
        check({pfx, "_acc"}, 32'(acc_cnt), 32'(NBL));
        check({pfx, "_rb_cnt"}, 32'(rb_cnt), 32'(NBL));
        check({pfx, "_rb_left"}, 32'(exp_q.size()), 32'd0);
        check({pfx, "_chain"}, 32'(ch_l == bv[LL-1:0]), 32'd1);
        check({pfx, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (ones) check({pfx, "_span"}, 32'(en_last - en_first + 1), 32'(LL));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; rb_en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        m_ready = 1'b1; sel = 1'b0; pre_ld_s = 1'b0; pre_ld_l = 1'b0;
        pre_s = '0; pre_l = '0;
        clr();
        fork
            monitor();
        join_none

        @(posedge clk);
        @(negedge clk);
        check("reset_s", 32'({cfg_en_s, cfg_bs_s, nn_s, s_ready_s, m_valid_s, busy_s, done_s, m_data_s}), 32'd0);
        check("reset_l", 32'({cfg_en_l, cfg_bs_l, nn_l, s_ready_l, m_valid_l, busy_l, done_l, m_data_l}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);

        run_small(0, 1'b1, "basic");
        run_small(3, 1'b1, "gap");

        // Reset partway through a load.
        pre_s = 12'hABC; pre_ld_s = 1'b1; tick(1); pre_ld_s = 1'b0;
        clr();
        sel = 1'b0;
        m_ready = 1'b1;
        do_start(1'b0);
        send_byte(8'h5A, 0);
        begin
            int t;
            t = 0;
            while (en_cnt < 5 && t < 100) begin @(posedge clk); t++; end
            if (en_cnt < 5) timeout("mid_bit5");
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out", 32'({cfg_en_m, busy_m, s_ready_m, m_valid_m, nn_m, done_m}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(10);
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_no_nn", 32'(nn_cnt), 32'd0);
        run_small(0, 1'b1, "rerun");

        // rb_en=0 with readback back-pressured, plus a start while busy.
        pre_s = 12'hABC; pre_ld_s = 1'b1; tick(1); pre_ld_s = 1'b0;
        clr();
        sel = 1'b0;
        m_ready = 1'b0;
        do_start(1'b0);
        send_byte(8'h5A, 0);
        rb_en = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_byte(8'h03, 0);
        wait_done("norb_done");
        tick(20);
        check("norb_en_cnt", 32'(en_cnt), 32'd12);
        check("norb_chain", 32'(ch_s), 32'h35A);
        check("norb_mvalid", 32'(mv_cnt), 32'd0);
        check("norb_done_cnt", 32'(done_cnt), 32'd1);
        check("norb_span", 32'(en_last - en_first + 1), 32'd12);
        check("norb_idle", 32'(busy_m), 32'd0);
        m_ready = 1'b1;

        run_large(1'b0, "stall");
        run_large(1'b1, "ones");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
